me_control: RTL and testbench

ME_CONTROL -- requirements
Module: me_control

---
 rtl/me_pkg.sv | 12 +
 rtl/me_control_if.sv | 25 ++
 rtl/me_pe_decode.sv | 20 ++
 rtl/me_control.sv | 79 +++++++
 tb/tb_me_control.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// me_pkg: shared sizes, counter limits and state encoding for the motion-estimation controller.
// Holds no logic; me_control, me_pe_decode and me_control_if import it.
package me_pkg;
    localparam int NUM_PE     = 16;
    localparam int DIST_W     = 8;
    localparam int VEC_W      = 4;
    localparam int LAST_COUNT = 4111;
    localparam int CNT_W      = 13;
    localparam int ADDR_R_W   = 8;
    localparam int ADDR_S_W   = 10;
    typedef enum logic [1:0] {IDLE, RUN, DONE} meStateT;
endpackage

// File: rtl/me_control_if.sv
// me_control_if: start/hold request pair plus the memory-address, PE-steering and comparator signals.
// master: the controller (takes start/hold, drives everything else); slave: memories, PE array, comparator.
interface me_control_if;
    import me_pkg::*;
    logic                  start;
    logic                  hold;
    logic                  busy;
    logic                  done;
    logic [ADDR_R_W-1:0]   AddressR;
    logic [ADDR_S_W-1:0]   AddressS1;
    logic [ADDR_S_W-1:0]   AddressS2;
    logic [NUM_PE-1:0]     S1S2mux;
    logic                  CompStart;
    logic [NUM_PE-1:0]     PEready;
    logic [VEC_W-1:0]      vectorX;
    logic [VEC_W-1:0]      vectorY;
    modport master (
        input  start, hold,
        output busy, done, AddressR, AddressS1, AddressS2, S1S2mux, CompStart, PEready, vectorX, vectorY
    );
    modport slave (
        output start, hold,
        input  busy, done, AddressR, AddressS1, AddressS2, S1S2mux, CompStart, PEready, vectorX, vectorY
    );
endinterface

// File: rtl/me_pe_decode.sv
// me_pe_decode: per-PE source select and distortion-ready strobe decoded from the low count bits.
// Ports: countLow (count[7:0]), compStart, hold in; s1s2Mux, peReady out (NUM_PE bits each).
module me_pe_decode import me_pkg::*; #(
    parameter int NUM_PE = me_pkg::NUM_PE
) (
    input  logic [7:0]        countLow,
    input  logic              compStart,
    input  logic              hold,
    output logic [NUM_PE-1:0] s1s2Mux,
    output logic [NUM_PE-1:0] peReady
);
    // PE i switches to S1 once the column index reaches i; it finishes a
    // distortion on row-cycle i of every row after the first.
    always_comb begin
        for (int i = 0; i < NUM_PE; i++) begin
            s1s2Mux[i] = countLow[3:0] >= 4'(i);
            peReady[i] = compStart && !hold && countLow == 8'(i);
        end
    end
endmodule

// File: rtl/me_control.sv
// me_control: sequences one full-search block match (IDLE -> RUN -> DONE) and decodes memory addresses,
// PE steering, comparator start and motion vectors from a 13-bit cycle counter.
// Ports: clock, reset_n (sync, active-low); bus (me_control_if.master) carries start/hold in and all outputs.
module me_control import me_pkg::*; #(
    parameter int NUM_PE     = me_pkg::NUM_PE,
    parameter int DIST_W     = me_pkg::DIST_W,
    parameter int LAST_COUNT = me_pkg::LAST_COUNT
) (
    input  logic         clock,
    input  logic         reset_n,
    me_control_if.master bus
);
    // Lanes are addressed by count[3:0], so more than 16 PEs cannot be served.
    if (NUM_PE < 1 || NUM_PE > 16 || DIST_W < 1 || LAST_COUNT >= 2**CNT_W) begin : gBadParams
        $error("me_control: unsupported parameter set");
    end

    meStateT             state, stateNext;
    logic [CNT_W-1:0]    count, countNext;
    logic                run;
    logic                compStart;
    logic [4:0]          blockSum;
    logic [ADDR_S_W-1:0] addrS1;
    logic [NUM_PE-1:0]   s1s2Mux;
    logic [NUM_PE-1:0]   peReady;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= stateNext;
            count <= countNext;
        end
    end

    // hold freezes both counter and state, so it wins over the final-count exit.
    always_comb begin
        stateNext = state;
        countNext = count;
        case (state)
            IDLE: if (bus.start) begin
                stateNext = RUN;
                countNext = '0;
            end
            RUN: if (!bus.hold) begin
                countNext = count + 1'b1;
                stateNext = count == CNT_W'(LAST_COUNT) ? DONE : RUN;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign run       = state == RUN;
    assign compStart = run && count >= CNT_W'(256);
    // Search window rows are 32 pixels wide: row = ref row + candidate row, column offset = count[3:0].
    assign blockSum  = {1'b0, count[11:8]} + {1'b0, count[7:4]};
    assign addrS1    = {blockSum, 5'd0} + ADDR_S_W'(count[3:0]);

    me_pe_decode #(.NUM_PE(NUM_PE)) peDecode (
        .countLow  (count[7:0]),
        .compStart (compStart),
        .hold      (bus.hold),
        .s1s2Mux   (s1s2Mux),
        .peReady   (peReady)
    );

    assign bus.busy      = run;
    assign bus.done      = state == DONE;
    assign bus.AddressR  = run ? count[7:0] : '0;
    assign bus.AddressS1 = run ? addrS1 : '0;
    assign bus.AddressS2 = run ? addrS1 + ADDR_S_W'(16) : '0;
    assign bus.S1S2mux   = run ? s1s2Mux : '0;
    assign bus.CompStart = compStart;
    assign bus.PEready   = peReady;
    assign bus.vectorX   = run ? count[3:0] : '0;
    // Distortions appear one row late; (count[12:8]-1) mod 16 equals count[11:8]-1 mod 16.
    assign bus.vectorY   = run ? count[11:8] - 4'd1 : '0;
endmodule

// File: tb/tb_me_control.sv
// tb_me_control: scoreboard bench for me_control; a behavioural model pushes expected outputs each cycle.
module tb_me_control;
    import me_pkg::*;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [7:0]  aR;
        logic [9:0]  s1;
        logic [9:0]  s2;
        logic [15:0] mux;
        logic        cs;
        logic [15:0] pe;
        logic [3:0]  vx;
        logic [3:0]  vy;
    } outT;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    me_control_if bus();

    me_control dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int  checks = 0;
    int  errors = 0;
    int  mState = 0;
    int  mCount = 0;
    bit  mValid = 0;
    int  doneSeen = 0;
    int  runCycles = 0;
    outT sbq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic outT modelOut(int st, int c, logic h);
        outT o;
        int  s1;
        o = '0;
        if (st == 1) begin
            s1     = ((((c >> 8) & 15) + ((c >> 4) & 15)) * 32 + (c & 15)) % 1024;
            o.busy = 1'b1;
            o.aR   = 8'(c & 255);
            o.s1   = 10'(s1);
            o.s2   = 10'((s1 + 16) % 1024);
            for (int i = 0; i < 16; i++) o.mux[i] = (c & 15) >= i;
            o.cs   = c >= 256;
            o.pe   = (c >= 256 && (c & 255) < 16 && !h) ? 16'(1 << (c & 255)) : 16'd0;
            o.vx   = 4'(c & 15);
            o.vy   = 4'(((c >> 8) - 1) & 15);
        end else if (st == 2) begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic spot(input outT g, input logic h);
        if (!mValid) return;
        if (mState == 0) begin
            check("idleBusy", g.busy, 0);
            check("idleDone", g.done, 0);
            check("idlePe", g.pe, 0);
            check("idleS2", g.s2, 0);
        end else if (mState == 2) begin
            check("donePulse", g.done, 1);
            check("doneBusy", g.busy, 0);
        end else begin
            if (mCount == 0) begin
                check("c0AddrR", g.aR, 0);
                check("c0AddrS1", g.s1, 0);
                check("c0AddrS2", g.s2, 16);
                check("c0Mux", g.mux, 16'h0001);
                check("c0CompStart", g.cs, 0);
            end
            if (mCount == 256) begin
                check("c256CompStart", g.cs, 1);
                check("c256Pe", g.pe, 16'h0001);
                check("c256Vx", g.vx, 0);
                check("c256Vy", g.vy, 0);
            end
            if (mCount == 257) begin
                check("c257Pe", g.pe, 16'h0002);
                check("c257Vx", g.vx, 1);
            end
            if (mCount == 258 && h) begin
                check("holdPe", g.pe, 0);
                check("holdAddrR", g.aR, 2);
                check("holdAddrS1", g.s1, 34);
                check("holdAddrS2", g.s2, 50);
            end
            if (mCount == 258 && !h) check("c258Pe", g.pe, 16'h0004);
            if (mCount == 259) check("c259Pe", g.pe, 16'h0008);
            if (mCount == 291) begin
                check("c291AddrR", g.aR, 8'h23);
                check("c291AddrS1", g.s1, 99);
                check("c291AddrS2", g.s2, 115);
                check("c291Pe", g.pe, 0);
                check("c291CompStart", g.cs, 1);
            end
            if (mCount == 1001) check("c1001AddrR", g.aR, 8'he9);
            if (mCount == 4111) begin
                check("lastPe", g.pe, 16'h8000);
                check("lastVx", g.vx, 15);
                check("lastVy", g.vy, 15);
            end
        end
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, sample mid-cycle, then advance the model.
    task automatic cycle(input logic s, input logic h, input logic r);
        outT e;
        outT g;
        bus.start = s;
        bus.hold  = h;
        reset_n   = r;
        if (mValid) sbq.push_back(modelOut(mState, mCount, h));
        #2;
        g.busy = bus.busy;
        g.done = bus.done;
        g.aR   = bus.AddressR;
        g.s1   = bus.AddressS1;
        g.s2   = bus.AddressS2;
        g.mux  = bus.S1S2mux;
        g.cs   = bus.CompStart;
        g.pe   = bus.PEready;
        g.vx   = bus.vectorX;
        g.vy   = bus.vectorY;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("sbBusy", g.busy, e.busy);
            check("sbDone", g.done, e.done);
            check("sbAddrR", g.aR, e.aR);
            check("sbAddrS1", g.s1, e.s1);
            check("sbAddrS2", g.s2, e.s2);
            check("sbMux", g.mux, e.mux);
            check("sbCompStart", g.cs, e.cs);
            check("sbPe", g.pe, e.pe);
            check("sbVx", g.vx, e.vx);
            check("sbVy", g.vy, e.vy);
        end
        spot(g, h);
        if (g.done === 1'b1) doneSeen++;
        if (g.busy === 1'b1 && !h) runCycles++;
        @(posedge clock);
        if (!r) begin
            mState = 0;
            mCount = 0;
            mValid = 1;
        end else begin
            case (mState)
                0: if (s) begin
                    mState = 1;
                    mCount = 0;
                end
                1: if (!h) begin
                    if (mCount == 4111) mState = 2;
                    mCount++;
                end
                default: mState = 0;
            endcase
        end
        #1;
    endtask

    initial begin
        logic h;
        int   guard;
        int   holdLeft;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        repeat (3) cycle(1, 0, 0);
        cycle(1, 0, 1);
        guard = 0;
        holdLeft = 3;
        doneSeen = 0;
        runCycles = 0;
        while (!(mState == 0 && doneSeen > 0) && guard < 6000) begin
            h = mState == 1 && mCount == 258 && holdLeft > 0;
            if (h) holdLeft--;
            cycle(0, h, 1);
            guard++;
        end
        check("runBound", guard < 6000, 1);
        cycle(0, 0, 1);
        check("doneCount", doneSeen, 1);
        check("runCycles", runCycles, 4112);
        doneSeen = 0;
        guard = 0;
        cycle(1, 0, 1);
        while (!(mState == 1 && mCount == 1000) && guard < 2000) begin
            cycle(0, 0, 1);
            guard++;
        end
        repeat (3) cycle(1, 0, 1);
        while (!(mState == 1 && mCount == 1500) && guard < 2000) begin
            cycle(0, 0, 1);
            guard++;
        end
        check("abortBound", guard < 2000, 1);
        repeat (2) cycle(0, 0, 0);
        repeat (3) cycle(0, 0, 1);
        check("abortNoDone", doneSeen, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
